// File: rtl/poly_bank_streamer.sv
// Read-side sequencer for the polynomial coefficient bank.
// Sweeps bank addresses 0..Depth-1 and absorbs the one-cycle registered read latency.
// Splits each packed word into a low and a high coefficient on a valid/ready stream.
// A 2-entry word FIFO plus a read credit check keep one coefficient per cycle without
// ever overrunning the FIFO.
module poly_bank_streamer #(
   parameter int unsigned AddrWidth  = 5,
   parameter int unsigned Depth      = 32,
   parameter int unsigned DataWidth  = 46,
   parameter int unsigned CoeffWidth = 23
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [AddrWidth-1:0]  bank_raddr_o,
   input  logic [DataWidth-1:0]  bank_rdata_i,
   output logic                  coeff_valid_o,
   input  logic                  coeff_ready_i,
   output logic [CoeffWidth-1:0] coeff_data_o,
   output logic                  coeff_last_o
);

   // One extra bit so the counters can hold Depth itself.
   localparam int unsigned CntWidth = AddrWidth + 1;
   localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
   localparam logic [CntWidth-1:0] LastIdx  = CntWidth'(Depth - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                state_q, state_d;
   logic [AddrWidth-1:0]  raddr_q, raddr_d;
   logic [CntWidth-1:0]   iss_cnt_q, iss_cnt_d;    // reads issued this run
   logic [CntWidth-1:0]   word_idx_q, word_idx_d;  // index of the FIFO head word within the run
   logic [1:0]            vld_q, vld_d;            // [0]: address loaded, [1]: data on bank_rdata_i
   logic                  half_q, half_d;          // 0: low half next, 1: high half next
   logic                  done_q, done_d;

   logic [DataWidth-1:0]  fifo_q [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;

   logic                  hs;
   logic                  pop;
   logic                  push;
   logic                  last_hs;
   logic                  issue;
   logic [2:0]            pending;
   logic [DataWidth-1:0]  head_word;

   // Stream-side decode: handshake, word pop, capture and read credit.
   always_comb begin
      head_word     = fifo_q[rd_ptr_q];
      coeff_valid_o = (count_q != 2'd0);
      coeff_last_o  = coeff_valid_o && half_q && (word_idx_q == LastIdx);
      coeff_data_o  = '0;
      if (coeff_valid_o) begin
         coeff_data_o = half_q ? head_word[DataWidth-1:CoeffWidth] : head_word[CoeffWidth-1:0];
      end
      hs      = coeff_valid_o && coeff_ready_i;
      pop     = hs && half_q;
      last_hs = hs && coeff_last_o;
      push    = vld_q[1];
      // Words held or on their way, less the one leaving now; the FIFO only has two slots.
      pending = 3'(count_q) + 3'(vld_q[0]) + 3'(vld_q[1]) - 3'(pop);
      issue   = (state_q == StRun) && (iss_cnt_q < DepthCnt) && (pending < 3'd2);
      busy_o  = (state_q == StRun);
      done_o  = done_q;
      bank_raddr_o = raddr_q;
   end

   // FSM next state, read issue and unpack bookkeeping.
   always_comb begin
      state_d    = state_q;
      raddr_d    = raddr_q;
      iss_cnt_d  = iss_cnt_q;
      vld_d      = {vld_q[0], 1'b0};
      word_idx_d = word_idx_q;
      half_d     = half_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d    = StRun;
               raddr_d    = '0;
               iss_cnt_d  = CntWidth'(1);
               vld_d[0]   = 1'b1;
               word_idx_d = '0;
               half_d     = 1'b0;
            end
         end
         StRun: begin
            if (issue) begin
               // The next address equals the number of reads already issued.
               raddr_d   = iss_cnt_q[AddrWidth-1:0];
               iss_cnt_d = iss_cnt_q + CntWidth'(1);
               vld_d[0]  = 1'b1;
            end
            if (hs) begin
               half_d = ~half_q;
            end
            if (pop) begin
               word_idx_d = word_idx_q + CntWidth'(1);
            end
            if (last_hs) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Word FIFO pointer and occupancy update.
   always_comb begin
      wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
      count_d  = count_q + 2'(push) - 2'(pop);
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         raddr_q    <= '0;
         iss_cnt_q  <= '0;
         vld_q      <= '0;
         word_idx_q <= '0;
         half_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         raddr_q    <= raddr_d;
         iss_cnt_q  <= iss_cnt_d;
         vld_q      <= vld_d;
         word_idx_q <= word_idx_d;
         half_q     <= half_d;
         done_q     <= done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Word FIFO storage; captures bank data two edges after its address was loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
      end else if (push) begin
         fifo_q[wr_ptr_q] <= bank_rdata_i;
      end
   end

endmodule

// File: tb/tb_poly_bank_streamer.sv
// Self-checking bench for poly_bank_streamer: registered-read bank model, a coefficient
// model derived from the bank contents, and directed scenarios with literal checkpoints.
module tb_poly_bank_streamer;

   localparam int AW = 5;
   localparam int D  = 32;
   localparam int DW = 46;
   localparam int CW = 23;
   localparam int NC = 2 * D;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          busy;
   logic          done;
   logic [AW-1:0] bank_raddr;
   logic [DW-1:0] bank_rdata;
   logic          coeff_valid;
   logic          coeff_ready;
   logic [CW-1:0] coeff_data;
   logic          coeff_last;

   logic [DW-1:0] bank_mem [D];

   int n_err    = 0;
   int n_checks = 0;

   // Model state
   int          exp_k     = 0;   // coefficients accepted since reset
   logic        exp_busy  = 1'b0;
   logic        exp_done  = 1'b0;
   logic        stall_prev = 1'b0;
   logic [CW-1:0] held_data;
   logic        held_last;
   int          hs_total  = 0;
   int          last_total = 0;
   int          done_total = 0;
   int          cyc       = 0;
   int          first_cyc = 0;
   int          last_cyc  = 0;

   poly_bank_streamer #(
      .AddrWidth (AW),
      .Depth     (D),
      .DataWidth (DW),
      .CoeffWidth(CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .busy_o       (busy),
      .done_o       (done),
      .bank_raddr_o (bank_raddr),
      .bank_rdata_i (bank_rdata),
      .coeff_valid_o(coeff_valid),
      .coeff_ready_i(coeff_ready),
      .coeff_data_o (coeff_data),
      .coeff_last_o (coeff_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank with a registered read address: data appears one cycle after sampling.
   always @(posedge clk) bank_rdata <= bank_mem[bank_raddr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Coefficient k of a run is half k%2 of bank word k/2.
   function automatic logic [CW-1:0] model_coeff(input int k);
      logic [DW-1:0] w;
      w = bank_mem[k / 2];
      return (k % 2 == 1) ? w[DW-1:CW] : w[CW-1:0];
   endfunction

   // Compare process: checks the DUT against the model on every cycle out of reset.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_k      = 0;
         exp_busy   = 1'b0;
         exp_done   = 1'b0;
         stall_prev = 1'b0;
      end else begin
         int  run_k;
         logic mlast;
         logic hs;
         cyc++;
         run_k = exp_k % NC;
         mlast = (run_k == NC - 1);
         hs    = coeff_valid && coeff_ready;
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("done", 64'(done), 64'(exp_done));
         if (done) done_total++;
         if (!exp_busy) chk("valid_idle", 64'(coeff_valid), 64'd0);
         if (stall_prev) begin
            chk("hold_valid", 64'(coeff_valid), 64'd1);
            chk("hold_data", 64'(coeff_data), 64'(held_data));
            chk("hold_last", 64'(coeff_last), 64'(held_last));
         end
         if (busy) chk("raddr_ahead", 64'(int'(bank_raddr) <= run_k / 2 + 1), 64'd1);
         if (hs) begin
            chk("coeff_data", 64'(coeff_data), 64'(model_coeff(run_k)));
            chk("coeff_last", 64'(coeff_last), 64'(mlast));
            if (run_k == 0) first_cyc = cyc;
            if (mlast) begin
               last_cyc = cyc;
               last_total++;
            end
            exp_k++;
            hs_total++;
         end
         exp_done = hs && mlast;
         exp_busy = exp_busy ? !(hs && mlast) : start;
         stall_prev = coeff_valid && !coeff_ready;
         held_data  = coeff_data;
         held_last  = coeff_last;
      end
   end

   // Pulse start for one cycle; checks the fixed start-to-first-valid timing.
   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;           // E0
      chk("e0_busy", 64'(busy), 64'd1);
      chk("e0_raddr", 64'(bank_raddr), 64'd0);
      chk("e0_valid", 64'(coeff_valid), 64'd0);
      @(posedge clk); #1;                        // E1
      chk("e1_valid", 64'(coeff_valid), 64'd0);
      chk("e1_raddr", 64'(bank_raddr), 64'd1);
      @(posedge clk); #1;                        // E2
      chk("e2_valid", 64'(coeff_valid), 64'd1);
      chk("e2_data", 64'(coeff_data), 64'd0);
   endtask

   // Wait (bounded) until the cycle holding the done pulse; optional random ready.
   task automatic wait_done(input bit rnd);
      bit seen = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1;
            break;
         end
         if (rnd) coeff_ready = 1'($urandom_range(0, 1));
      end
      chk("done_timeout", 64'(seen), 64'd1);
      coeff_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      int dn0;
      int ls0;
      bit hit;
      for (int i = 0; i < D; i++) bank_mem[i] = {CW'(2 * i + 1), CW'(2 * i)};
      rst_n = 1'b0;
      start = 1'b0;
      coeff_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_valid", 64'(coeff_valid), 64'd0);
      chk("rst_raddr", 64'(bank_raddr), 64'd0);
      chk("rst_data", 64'(coeff_data), 64'd0);
      chk("rst_last", 64'(coeff_last), 64'd0);
      rst_n = 1'b1;

      // Basic stream with ready held high.
      hs0 = hs_total;
      pulse_start();
      @(posedge clk); #1;
      chk("basic_k1_data", 64'(coeff_data), 64'd1);
      wait_done(0);
      chk("basic_count", 64'(hs_total - hs0), 64'(NC));
      chk("basic_span", 64'(last_cyc - first_cyc), 64'(NC - 1));
      @(posedge clk); #1;
      chk("basic_busy_after", 64'(busy), 64'd0);
      chk("basic_done_after", 64'(done), 64'd0);

      // Random backpressure.
      hs0 = hs_total;
      pulse_start();
      wait_done(1);
      chk("rand_count", 64'(hs_total - hs0), 64'(NC));

      // Full stall after the first valid, then resume.
      repeat (3) @(posedge clk);
      #1 coeff_ready = 1'b0;
      hs0 = hs_total;
      pulse_start();
      repeat (20) @(posedge clk);
      #1;
      chk("stall_valid", 64'(coeff_valid), 64'd1);
      chk("stall_data", 64'(coeff_data), 64'd0);
      chk("stall_raddr", 64'(bank_raddr), 64'd1);
      chk("stall_count", 64'(hs_total - hs0), 64'd0);
      coeff_ready = 1'b1;
      wait_done(0);
      chk("stall_total", 64'(hs_total - hs0), 64'(NC));
      chk("stall_span", 64'(last_cyc - first_cyc), 64'(NC - 1));

      // Start while busy is ignored.
      repeat (2) @(posedge clk);
      hs0 = hs_total;
      dn0 = done_total;
      pulse_start();
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(0);
      repeat (5) @(posedge clk);
      #1;
      chk("ign_count", 64'(hs_total - hs0), 64'(NC));
      chk("ign_done_pulses", 64'(done_total - dn0), 64'd1);
      chk("ign_busy", 64'(busy), 64'd0);

      // Reset mid-run after coefficient 17.
      hs0 = hs_total;
      pulse_start();
      hit = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (hs_total - hs0 == 18) begin
            hit = 1;
            break;
         end
      end
      chk("mid_reach18", 64'(hit), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_valid", 64'(coeff_valid), 64'd0);
      chk("mid_data", 64'(coeff_data), 64'd0);
      chk("mid_raddr", 64'(bank_raddr), 64'd0);
      chk("mid_last", 64'(coeff_last), 64'd0);
      chk("mid_done", 64'(done), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_no_stale", 64'(coeff_valid), 64'd0);
      hs0 = hs_total;
      pulse_start();
      wait_done(0);
      chk("mid_restart_count", 64'(hs_total - hs0), 64'(NC));

      // Back-to-back runs: second start in the done cycle.
      repeat (2) @(posedge clk);
      hs0 = hs_total;
      ls0 = last_total;
      pulse_start();
      wait_done(0);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_raddr", 64'(bank_raddr), 64'd0);
      wait_done(0);
      chk("b2b_count", 64'(hs_total - hs0), 64'(2 * NC));
      chk("b2b_lasts", 64'(last_total - ls0), 64'd2);
      chk("b2b_span", 64'(last_cyc - first_cyc), 64'(NC - 1));

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/poly_bank_streamer.md
# poly_bank_streamer

Read-side sequencer placed directly downstream of the polynomial coefficient bank. On a start pulse it drives the bank read address through every word, absorbs the bank's one-cycle registered-address read latency, splits each packed word into two coefficients, and presents them on a valid/ready stream to the next arithmetic stage. The stage sustains one coefficient per cycle under no backpressure, and stalls cleanly under backpressure without dropping or duplicating data.

## Interface
- addr_width, 5, bank address width
- depth, 32, number of bank words streamed per run (addresses 0..depth-1)
- data_width, 46, bank word width; must equal 2*coeff_width
- coeff_width, 23, width of one coefficient
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only while busy=0
- busy  out  1  high from the start-accept edge until the edge that accepts the last coefficient
- done  out  1  one-cycle pulse after the last coefficient is accepted
- bank_raddr  out  addr_width  registered read address to the bank
- bank_rdata  in  data_width  bank read data; valid in the cycle after the bank samples bank_raddr
- coeff_valid  out  1  output coefficient valid
- coeff_ready  in  1  downstream accept
- coeff_data  out  coeff_width  output coefficient
- coeff_last  out  1  high with the final coefficient of a run (index 2*depth-1)

## Operation
- States:
  - IDLE: waits for start.
  - RUN: issues reads and streams coefficients.
  - IDLE -> RUN on start=1 while in IDLE.
  - RUN -> IDLE on the handshake of the coefficient with coeff_last=1.
- start while busy=1 is ignored.
- Read issue:
  - A read issues when bank_raddr is loaded with the next address. The first read of a run loads address 0 on the start-accept edge.
  - Addresses increase by 1 and stop after depth-1; there is no wrap within a run.
  - Issue condition: addresses remain, and (word-FIFO occupancy + reads in flight − word popped this cycle) < 2.
- Capture:
  - A 2-bit valid pipeline tracks in-flight reads.
  - bank_rdata is written into the word FIFO exactly two edges after the edge that loaded bank_raddr.
  - The word FIFO is 2 entries deep and can never overflow, by construction of the issue condition.
- Unpack:
  - From the head word, the low half [coeff_width-1:0] is presented first, then the high half [data_width-1:coeff_width].
  - The head word pops when its high half handshakes.
  - Coefficient k of the run is word k/2, half k%2.
- Output rule:
  - coeff_valid=1 whenever the FIFO is non-empty.
  - Once coeff_valid is asserted, coeff_valid, coeff_data and coeff_last hold stable until coeff_ready=1.
  - Handshake = coeff_valid & coeff_ready.
- coeff_last=1 only on the high half of word depth-1.
- The bank write port must not target addresses of the active run while busy=1; this is a system-level rule and is not checked by this block.
- Reset (asynchronous, any state, including mid-run):
  - State returns to IDLE.
  - busy, done, coeff_valid, coeff_last all 0.
  - coeff_data and bank_raddr = 0.
  - FIFO and in-flight pipeline cleared.
  - After rst_n deasserts, no stale coefficient ever appears.

## Timing
- Start accepted at edge E0:
  - busy=1 and bank_raddr=0 after E0.
  - Word 0 is captured at E2, so coeff_valid=1 from after E2.
  - Latency from start to the first coefficient is 2 cycles.
- With coeff_ready held at 1:
  - one coefficient per cycle, no bubbles;
  - bank_raddr advances once every 2 cycles in steady state;
  - a full run takes 2*depth cycles of valid output (64 for the defaults).
- The last handshake at edge En drops busy and pulses done=1 for the cycle after En.
- A new start is accepted from the cycle after En; it may coincide with the done pulse.
- Under backpressure no read issues beyond the 2-word credit; bank_raddr holds its value.

## Test plan
- Basic stream: bank[i] = {2i+1, 2i} (coeff_width each), ready=1, pulse start → coefficients 0,1,…,63 in consecutive cycles; first valid 2 cycles after start; coeff_last on 63; done one cycle later; busy low.
- Random backpressure: ready toggled with 50% random pattern → identical sequence 0..63; no duplicates or drops; valid/data stable while ready=0; bank_raddr never runs more than 2 words ahead of the consumed word.
- Full stall: hold ready=0 for 20 cycles after the first valid → coeff_data=0 stays stable, exactly 2 reads issued (addresses 0,1); resume → stream continues at 1 coefficient/cycle.
- start while busy: second start pulse mid-run → ignored; exactly 64 coefficients and one done pulse.
- Reset mid-run: assert rst_n=0 after coefficient 17 → all outputs 0 immediately; new start after release → stream restarts at coefficient 0.
- Back-to-back runs: start asserted in the done cycle → second run accepted; bank_raddr=0 again; 128 total coefficients with correct coeff_last positions.
